// File: rtl/score_display_n.sv
// rtl/score_display_n.sv - N-digit BCD score counter with high score and multiplexed 7-segment driver
module score_display_n #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 1,
   parameter int SATURATE    = 0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic                    invert,
   input  logic                    blank_lz,
   input  logic                    show_hi,
   input  logic                    clr,
   input  logic                    inc,
   input  logic                    dec,
   input  logic                    commit,
   output logic [4*NUM_DIGITS-1:0] score,
   output logic [4*NUM_DIGITS-1:0] hi_score,
   output logic                    overflow,
   output logic [6:0]              segments,
   output logic [NUM_DIGITS-1:0]   digits
);

   localparam int W  = 4 * NUM_DIGITS;
   localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

   logic [W-1:0]          inc_val;
   logic [W-1:0]          dec_val;
   logic                  at_max;
   logic                  at_zero;
   logic                  carry;
   logic                  borrow;
   logic [3:0]            cd;

   logic [PW-1:0]         pre;
   logic [IW-1:0]         idx;

   logic [W-1:0]          shown;
   logic [3:0]            cur;
   logic                  upper_zero;
   logic                  blank;
   logic [6:0]            seg_raw;
   logic [NUM_DIGITS-1:0] onehot;

   // BCD ripple increment/decrement candidates and limit detection.
   // Ripple naturally wraps: all-nines +1 gives zero, zero -1 gives all-nines.
   always_comb begin
      inc_val = score;
      dec_val = score;
      carry   = 1'b1;
      borrow  = 1'b1;
      at_max  = 1'b1;
      at_zero = 1'b1;
      cd      = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         cd = score[4*i +: 4];
         if (cd != 4'd9) at_max = 1'b0;
         if (cd != 4'd0) at_zero = 1'b0;
         if (carry) begin
            if (cd == 4'd9) begin
               inc_val[4*i +: 4] = 4'd0;
            end else begin
               inc_val[4*i +: 4] = cd + 4'd1;
               carry = 1'b0;
            end
         end
         if (borrow) begin
            if (cd == 4'd0) begin
               dec_val[4*i +: 4] = 4'd9;
            end else begin
               dec_val[4*i +: 4] = cd - 4'd1;
               borrow = 1'b0;
            end
         end
      end
   end

   // Score register: clr wins, inc+dec together cancel, limits wrap or hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         score    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= 1'b0;
         if (clr) begin
            score <= '0;
         end else if (inc && dec) begin
            score <= score;
         end else if (inc) begin
            if (at_max) begin
               overflow <= 1'b1;
               if (SATURATE == 0) score <= inc_val;
            end else begin
               score <= inc_val;
            end
         end else if (dec) begin
            if (at_zero) begin
               overflow <= 1'b1;
               if (SATURATE == 0) score <= dec_val;
            end else begin
               score <= dec_val;
            end
         end
      end
   end

   // High score: packed BCD compares like binary, uses pre-update score.
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_score <= '0;
      end else if (commit && (score > hi_score)) begin
         hi_score <= score;
      end
   end

   // Scan prescaler and digit index.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre <= '0;
         idx <= '0;
      end else if (pre == PRE_LAST) begin
         pre <= '0;
         idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
      end else begin
         pre <= pre + PW'(1);
      end
   end

   // Select active digit, decide blanking and encode segments.
   always_comb begin
      shown      = show_hi ? hi_score : score;
      cur        = 4'd0;
      upper_zero = 1'b1;
      onehot     = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (IW'(i) == idx) begin
            cur       = shown[4*i +: 4];
            onehot[i] = 1'b1;
         end
         if ((IW'(i) >= idx) && (shown[4*i +: 4] != 4'd0)) upper_zero = 1'b0;
      end
      blank = !ena || (blank_lz && (idx != '0) && upper_zero);
      case (cur)
         4'd0:    seg_raw = 7'b0111111;
         4'd1:    seg_raw = 7'b0000110;
         4'd2:    seg_raw = 7'b1011011;
         4'd3:    seg_raw = 7'b1001111;
         4'd4:    seg_raw = 7'b1100110;
         4'd5:    seg_raw = 7'b1101101;
         4'd6:    seg_raw = 7'b1111101;
         4'd7:    seg_raw = 7'b0000111;
         4'd8:    seg_raw = 7'b1111111;
         4'd9:    seg_raw = 7'b1101111;
         default: seg_raw = 7'b0000000;
      endcase
      if (blank) seg_raw = 7'b0000000;
   end

   // Registered pin drivers with polarity applied.
   always_ff @(posedge clk) begin
      if (rst) begin
         segments <= '0;
         digits   <= '0;
      end else begin
         segments <= invert ? ~seg_raw : seg_raw;
         digits   <= invert ? ~onehot : onehot;
      end
   end

endmodule
